// File: rtl/inst_rom_arbiter.sv
// Instruction ROM arbiter: shares one single-port ROM between
// the fetch port (0) and the debug/loader port (1).
module inst_rom_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_err_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              stallreq_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              rom_ce_q, rom_ce_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              if_ack_q, if_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              if_err_q, if_err_d;
    logic              dbg_err_q, dbg_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic              aligned;

    // Pick the winning port; on a tie round-robin favours the port not served last
    always_comb begin
        win = dbg_req_i;
        if (if_req_i && dbg_req_i) begin
            win = RR_EN ? ~last_gnt_q : 1'b0;
        end
        win_addr = win ? dbg_addr_i : if_addr_i;
        aligned  = (win_addr[1:0] == 2'b00);
    end

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        rom_ce_d    = 1'b0;
        rom_addr_d  = '0;
        if_ack_d    = 1'b0;
        dbg_ack_d   = 1'b0;
        if_err_d    = 1'b0;
        dbg_err_d   = 1'b0;
        if_rdata_d  = '0;
        dbg_rdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (if_req_i || dbg_req_i) begin
                    gnt_d = win;
                    if (aligned) begin
                        state_d    = ISSUE;
                        rom_ce_d   = 1'b1;
                        rom_addr_d = win_addr;
                    end else begin
                        state_d   = RESP;
                        if_ack_d  = ~win;
                        dbg_ack_d = win;
                        if_err_d  = ~win;
                        dbg_err_d = win;
                    end
                end
            end
            ISSUE: begin
                state_d   = RESP;
                if_ack_d  = ~gnt_q;
                dbg_ack_d = gnt_q;
                if (gnt_q) begin
                    dbg_rdata_d = rom_data_i;
                end else begin
                    if_rdata_d = rom_data_i;
                end
            end
            RESP: begin
                state_d    = IDLE;
                last_gnt_d = gnt_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            rom_ce_q    <= 1'b0;
            rom_addr_q  <= '0;
            if_ack_q    <= 1'b0;
            dbg_ack_q   <= 1'b0;
            if_err_q    <= 1'b0;
            dbg_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            rom_ce_q    <= rom_ce_d;
            rom_addr_q  <= rom_addr_d;
            if_ack_q    <= if_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            if_err_q    <= if_err_d;
            dbg_err_q   <= dbg_err_d;
            if_rdata_q  <= if_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign if_ack_o    = if_ack_q;
    assign dbg_ack_o   = dbg_ack_q;
    assign if_err_o    = if_err_q;
    assign dbg_err_o   = dbg_err_q;
    assign if_rdata_o  = if_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign rom_ce_o    = rom_ce_q;
    assign rom_addr_o  = rom_addr_q;
    assign busy_o      = (state_q != IDLE);
    assign stallreq_o  = if_req_i & ~if_ack_q;

endmodule
